// File: rtl/unsadd_acc_n_if.sv
// unsadd_acc_n_if: stream bundle between unary producers and the non-scaled adder
// Ports: en/in driven by the producer side (master); out/acc_o/sat driven by the adder (slave).
interface unsadd_acc_n_if #(
  parameter int NUM_IN = 16,
  parameter int ACC_W  = 8
);
  logic              en;
  logic [NUM_IN-1:0] in;
  logic              out;
  logic [ACC_W-1:0]  acc_o;
  logic              sat;
  modport master (output en, in, input out, acc_o, sat);
  modport slave  (input en, in, output out, acc_o, sat);
endinterface

// File: rtl/unsadd_acc_n.sv
// unsadd_acc_n: unary non-scaled adder, sums NUM_IN unipolar streams into one saturating residue-drained stream
// Ports: clk, rst (sync, active-high); bus.en/bus.in stream input; bus.out bitstream, bus.acc_o residue, bus.sat sticky clamp flag.
module unsadd_acc_n #(
  parameter int NUM_IN = 16,
  parameter int ACC_W  = 8,
  parameter int PIPE   = 0
) (
  input logic           clk,
  input logic           rst,
  unsadd_acc_n_if.slave bus
);
  localparam int CW = $clog2(NUM_IN + 1);
  logic [CW-1:0]    w_cnt;
  logic             w_e;
  logic [CW-1:0]    w_c;
  logic [ACC_W:0]   w_sum;
  logic             w_o;
  logic [ACC_W:0]   w_raw;
  logic [ACC_W-1:0] r_acc;
  logic             r_out;
  logic             r_sat;
  always_comb begin
    w_cnt = '0;
    for (int k = 0; k < NUM_IN; k++) w_cnt = w_cnt + CW'(bus.in[k]);
  end
  if (PIPE != 0) begin : g_pipe
    logic          r_en;
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_en  <= 1'b0;
        r_cnt <= '0;
      end else begin
        r_en  <= bus.en;
        r_cnt <= bus.en ? w_cnt : '0;
      end
    end
    assign w_e = r_en;
    assign w_c = r_cnt;
  end else begin : g_comb
    assign w_e = bus.en;
    assign w_c = w_cnt;
  end
  // acc + cnt never exceeds 2*MAX since ACC_W >= CW, so the extra bit flags clamping
  always_comb begin
    w_sum = {1'b0, r_acc} + (w_e ? (ACC_W+1)'(w_c) : '0);
    w_o   = |w_sum;
    w_raw = w_sum - (ACC_W+1)'(w_o);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_out <= 1'b0;
      r_sat <= 1'b0;
    end else begin
      r_acc <= w_raw[ACC_W] ? '1 : w_raw[ACC_W-1:0];
      r_out <= w_o;
      r_sat <= r_sat | w_raw[ACC_W];
    end
  end
  assign bus.out   = r_out;
  assign bus.acc_o = r_acc;
  assign bus.sat   = r_sat;
endmodule

// File: tb/tb_unsadd_acc_n.sv
// tb_unsadd_acc_n: randomized and directed checks of both PIPE variants against a residue-count model
module tb_unsadd_acc_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  unsadd_acc_n_if #(.NUM_IN(16), .ACC_W(8)) b0 ();
  unsadd_acc_n_if #(.NUM_IN(16), .ACC_W(8)) b1 ();
  unsadd_acc_n #(.NUM_IN(16), .ACC_W(8), .PIPE(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  unsadd_acc_n #(.NUM_IN(16), .ACC_W(8), .PIPE(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  int n_tests = 0;
  int n_fail  = 0;
  int m0_res, m1_res, m1_pend;
  bit m0_out, m0_sat, m1_out, m1_sat;
  int tot_in0, tot_out0, tot_in1, tot_out1;
  task automatic acc_model(inout int res, inout bit o, inout bit s, input int c);
    res = res + c;
    o = res > 0;
    if (o) res = res - 1;
    if (res > 255) begin
      res = 255;
      s = 1'b1;
    end
  endtask
  task automatic step(input logic r, input logic e, input logic [15:0] v);
    int c0, c1;
    rst = r;
    b0.en = e; b0.in = v;
    b1.en = e; b1.in = v;
    c0 = e ? $countones(v) : 0;
    @(posedge clk);
    if (r) begin
      m0_res = 0; m0_out = 0; m0_sat = 0;
      m1_res = 0; m1_out = 0; m1_sat = 0; m1_pend = 0;
      tot_in0 = 0; tot_out0 = 0; tot_in1 = 0; tot_out1 = 0;
    end else begin
      c1 = m1_pend;
      m1_pend = c0;
      acc_model(m0_res, m0_out, m0_sat, c0);
      acc_model(m1_res, m1_out, m1_sat, c1);
      tot_in0 += c0;
      tot_in1 += c1;
    end
    #1;
    if (!r) begin
      tot_out0 += int'(b0.out);
      tot_out1 += int'(b1.out);
    end
  endtask
  task automatic test_reset();
    step(1'b1, 1'b1, 16'hFFFF);
    step(1'b1, 1'b1, 16'hFFFF);
    n_tests++;
    if ({b0.out, b0.acc_o, b0.sat, b1.out, b1.acc_o, b1.sat} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset: got p0 out=%b acc=%0d sat=%b p1 out=%b acc=%0d sat=%b, want all 0",
               b0.out, b0.acc_o, b0.sat, b1.out, b1.acc_o, b1.sat);
    end
  endtask
  task automatic test_saturate();
    step(1'b1, 1'b0, 16'h0);
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b1, 16'hFFFF);
      n_tests++;
      if (b0.out !== 1'b1 || b0.acc_o !== 8'((i * 15 > 255) ? 255 : i * 15) || b0.sat !== (i >= 18)) begin
        n_fail++;
        $display("FAIL saturate edge %0d: got out=%b acc=%0d sat=%b, want out=1 acc=%0d sat=%b",
                 i, b0.out, b0.acc_o, b0.sat, (i * 15 > 255) ? 255 : i * 15, i >= 18);
      end
    end
  endtask
  task automatic test_half_drain();
    int ones;
    step(1'b1, 1'b0, 16'h0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b1, 16'hFF00);
      n_tests++;
      if (b0.out !== 1'b1 || b0.acc_o !== 8'(7 * i) || b0.sat !== 1'b0) begin
        n_fail++;
        $display("FAIL half edge %0d: got out=%b acc=%0d sat=%b, want out=1 acc=%0d sat=0",
                 i, b0.out, b0.acc_o, b0.sat, 7 * i);
      end
    end
    ones = 0;
    for (int i = 0; i < 80; i++) begin
      step(1'b0, 1'b1, 16'h0000);
      ones += int'(b0.out);
      if (i == 69 || i == 70) begin
        n_tests++;
        if (b0.out !== (i == 69)) begin
          n_fail++;
          $display("FAIL drain tail cycle %0d: got out=%b, want %b", i + 1, b0.out, i == 69);
        end
      end
    end
    n_tests++;
    if (ones != 70 || b0.acc_o !== 8'd0) begin
      n_fail++;
      $display("FAIL drain: got %0d ones acc=%0d, want 70 ones acc=0", ones, b0.acc_o);
    end
    n_tests++;
    if (tot_out0 != tot_in0 - int'(b0.acc_o)) begin
      n_fail++;
      $display("FAIL drain scoreboard: got out total %0d, want %0d", tot_out0, tot_in0 - int'(b0.acc_o));
    end
  endtask
  task automatic test_single();
    step(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 16'h0001);
      n_tests++;
      if (b0.out !== 1'b1 || b0.acc_o !== 8'd0) begin
        n_fail++;
        $display("FAIL single: got out=%b acc=%0d, want out=1 acc=0", b0.out, b0.acc_o);
      end
    end
    step(1'b0, 1'b1, 16'h0000);
    n_tests++;
    if (b0.out !== 1'b0 || b0.acc_o !== 8'd0) begin
      n_fail++;
      $display("FAIL single stop: got out=%b acc=%0d, want out=0 acc=0", b0.out, b0.acc_o);
    end
  endtask
  task automatic test_pipe();
    logic [3:0] exp_o;
    logic [7:0] exp_a [6];
    exp_o = 4'b0;
    exp_a = '{8'd0, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0};
    step(1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'hF000);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step(1'b0, 1'b0, 16'hFFFF);
      n_tests++;
      if (b1.out !== (i >= 1 && i <= 4) || b1.acc_o !== exp_a[i]) begin
        n_fail++;
        $display("FAIL pipe edge %0d: got out=%b acc=%0d, want out=%b acc=%0d",
                 i + 1, b1.out, b1.acc_o, i >= 1 && i <= 4, exp_a[i]);
      end
    end
    n_tests++;
    if (tot_out1 != 4 || exp_o !== 4'b0) begin
      n_fail++;
      $display("FAIL pipe total: got %0d ones, want 4", tot_out1);
    end
  endtask
  task automatic test_midreset();
    step(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'hFFFF);
    n_tests++;
    if (b0.acc_o !== 8'd120) begin
      n_fail++;
      $display("FAIL midreset pre: got acc=%0d, want 120", b0.acc_o);
    end
    step(1'b1, 1'b1, 16'hFFFF);
    n_tests++;
    if ({b0.out, b0.acc_o, b0.sat, b1.out, b1.acc_o, b1.sat} !== 20'h0) begin
      n_fail++;
      $display("FAIL midreset: got p0 out=%b acc=%0d sat=%b p1 out=%b acc=%0d, want all 0",
               b0.out, b0.acc_o, b0.sat, b1.out, b1.acc_o);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 16'hFFFF);
      n_tests++;
      if (b0.out !== 1'b0 || b1.out !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset residual: got p0 out=%b p1 out=%b, want 0 0", b0.out, b1.out);
      end
    end
  endtask
  task automatic test_random();
    logic [15:0] v;
    step(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 600; i++) begin
      v = 16'($urandom) & 16'($urandom) & 16'($urandom);
      if (i > 400) v = 16'($urandom);
      step($urandom_range(99) == 0, 1'($urandom), v);
      n_tests++;
      if ({b0.out, b0.acc_o, b0.sat, b1.out, b1.acc_o, b1.sat} !==
          {m0_out, 8'(m0_res), m0_sat, m1_out, 8'(m1_res), m1_sat}) begin
        n_fail++;
        $display("FAIL random cycle %0d: got p0 %b/%0d/%b p1 %b/%0d/%b, want p0 %b/%0d/%b p1 %b/%0d/%b",
                 i, b0.out, b0.acc_o, b0.sat, b1.out, b1.acc_o, b1.sat,
                 m0_out, m0_res, m0_sat, m1_out, m1_res, m1_sat);
      end
      if (!m0_sat) begin
        n_tests++;
        if (tot_out0 != tot_in0 - int'(b0.acc_o)) begin
          n_fail++;
          $display("FAIL random scoreboard p0 cycle %0d: got %0d ones, want %0d", i, tot_out0, tot_in0 - int'(b0.acc_o));
        end
      end
      if (!m1_sat) begin
        n_tests++;
        if (tot_out1 != tot_in1 - int'(b1.acc_o)) begin
          n_fail++;
          $display("FAIL random scoreboard p1 cycle %0d: got %0d ones, want %0d", i, tot_out1, tot_in1 - int'(b1.acc_o));
        end
      end
    end
  endtask
  initial begin
    b0.en = 1'b0; b0.in = '0;
    b1.en = 1'b0; b1.in = '0;
    test_reset();
    test_saturate();
    test_half_drain();
    test_single();
    test_pipe();
    test_midreset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
